audio_out: RTL and testbench

Output stage directly downstream of `filter`: takes the filter's 16-bit offset-binary sample on each sample-rate strobe and applies a soft-ramped 8-bit gain with a sequential shift-add multiplier. It drives a first-order sigma-delta modulator that produces the 1-bit PDM pin feeding the external RC reconstruction network. Mute ramps the gain to zero, so output density settles at 50 % without clicks.

---
 rtl/audio_pkg.sv | 25 ++
 rtl/pdm_mod.sv | 39 +++
 rtl/audio_out.sv | 126 ++++++++++++
 tb/tb_audio_out.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio output path: widths, FSM state type and
// offset-binary <-> two's-complement conversion helpers (also used by the tone
// generator upstream of the filter).
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned GAIN_W   = 8;
    localparam logic [15:0] MIDSCALE = 16'h8000;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StLoad
    } audio_state_e;

    // Flipping the MSB maps offset-binary midscale (0x8000) onto signed zero.
    function automatic logic signed [15:0] ob_to_tc(input logic [15:0] ob);
        return signed'(ob ^ MIDSCALE);
    endfunction

    function automatic logic [15:0] tc_to_ob(input logic signed [15:0] tc);
        return unsigned'(tc) ^ MIDSCALE;
    endfunction

endpackage

// File: rtl/pdm_mod.sv
// First-order sigma-delta modulator: accumulates the offset-binary level every
// cycle and emits the carry as a registered 1-bit PDM stream. Long-run density
// of ones is level / 2^LEVEL_W.
module pdm_mod
    import audio_pkg::*;
#(
    parameter int unsigned LEVEL_W = SAMPLE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] level,
    output logic               pdm_out
);

    logic [LEVEL_W-1:0] err_q, err_d;
    logic               pdm_q, pdm_d;
    logic [LEVEL_W:0]   sum;

    // Error accumulation; the carry out of the add is the modulator bit.
    always_comb begin
        sum   = {1'b0, err_q} + {1'b0, level};
        err_d = sum[LEVEL_W-1:0];
        pdm_d = sum[LEVEL_W];
    end

    // Error and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            err_q <= err_d;
            pdm_q <= pdm_d;
        end
    end

    assign pdm_out = pdm_q;

endmodule

// File: rtl/audio_out.sv
// Audio output stage: accepts one offset-binary sample per strobe, scales it by
// a soft-ramped gain using a bit-serial shift-add multiplier, and hands the
// result to the PDM modulator. The gain moves one LSB per accepted sample so
// volume and mute changes never produce clicks.
module audio_out
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned GAIN_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                sample_ready,
    input  logic [GAIN_W-1:0]   volume,
    input  logic                mute,
    output logic                overrun,
    output logic                pdm_out
);

    localparam int unsigned ACC_W = SAMPLE_W + GAIN_W;
    localparam int unsigned CNT_W = $clog2(GAIN_W);

    audio_state_e state_q, state_d;

    logic signed [SAMPLE_W-1:0] s_q, s_d;
    logic [GAIN_W-1:0]          g_q, g_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]        level_q, level_d;
    logic                       overrun_q, overrun_d;

    logic [GAIN_W-1:0]          target;
    logic signed [ACC_W-1:0]    s_ext;
    logic signed [ACC_W-1:0]    partial;

    // Next-state logic for the accept / multiply / load sequence.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        g_d       = g_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        overrun_d = overrun_q;

        sample_ready = (state_q == StIdle);
        target       = mute ? '0 : volume;
        s_ext        = {{GAIN_W{s_q[SAMPLE_W-1]}}, s_q};
        partial      = s_ext <<< cnt_q;

        unique case (state_q)
            StIdle: begin
                if (sample_valid) begin
                    s_d = ob_to_tc(sample);
                    // Gain ramps one LSB per accepted sample toward the target.
                    if (g_q < target) begin
                        g_d = g_q + GAIN_W'(1);
                    end else if (g_q > target) begin
                        g_d = g_q - GAIN_W'(1);
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StMult;
                end
            end
            StMult: begin
                // One gain bit per cycle, LSB first.
                if (g_q[cnt_q]) begin
                    acc_d = acc_q + partial;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GAIN_W - 1)) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // acc >>> GAIN_W truncated to SAMPLE_W bits, back to offset-binary.
                level_d = {~acc_q[ACC_W-1], acc_q[ACC_W-2:GAIN_W]};
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A strobe while busy is dropped and flagged until reset.
        if (sample_valid && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    // State registers; reset wins over any strobe in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            s_q       <= '0;
            g_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            level_q   <= MIDSCALE;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            g_q       <= g_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;

    pdm_mod #(
        .LEVEL_W(SAMPLE_W)
    ) u_pdm_mod (
        .clk    (clk),
        .rst    (rst),
        .level  (level_q),
        .pdm_out(pdm_out)
    );

endmodule

// File: tb/tb_audio_out.sv
// Directed bench for audio_out: scoreboard of expected levels computed with
// integer arithmetic, compared when each sample has been processed.
module tb_audio_out;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = 16'h8000;
    logic        sample_ready;
    logic [7:0]  volume = 8'd0;
    logic        mute = 1'b0;
    logic        overrun;
    logic        pdm_out;

    int checks = 0;
    int failures = 0;
    int gm = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    audio_out dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample      (sample),
        .sample_ready(sample_ready),
        .volume      (volume),
        .mute        (mute),
        .overrun     (overrun),
        .pdm_out     (pdm_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_level(input logic [15:0] smp, input int g);
        int s;
        int p;
        int sc;
        s  = int'(smp) - 32768;
        p  = s * g;
        sc = p >>> 8;
        return 16'(sc + 32768);
    endfunction

    task automatic step_gain(input logic [7:0] vol, input logic m);
        int t;
        t = m ? 0 : int'(vol);
        if (gm < t) gm++;
        else if (gm > t) gm--;
    endtask

    // Strobe in cycle 0, check ready returns in cycle 10, compare level and gain.
    task automatic send(input logic [15:0] smp, input logic [7:0] vol, input logic m,
                        input int spacing);
        int n;
        sample = smp;
        volume = vol;
        mute = m;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        step_gain(vol, m);
        exp_q.push_back(exp_level(smp, gm));
        n = 1;
        while (!sample_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_cycle", n, 10);
        check("gain", dut.g_q, gm);
        check("level", dut.level_q, exp_q.pop_front());
        for (int i = n; i < spacing; i++) tick();
    endtask

    initial begin
        int ones;
        logic [15:0] bits;
        logic [15:0] prev;
        int diff;

        // Reset state and idle modulator pattern
        repeat (3) tick();
        check("rst_ready", sample_ready, 1);
        check("rst_overrun", overrun, 0);
        check("rst_pdm", pdm_out, 0);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("idle_pdm", pdm_out, (k % 2 == 0) ? 1 : 0);
        end
        check("idle_level", dut.level_q, 16'h8000);
        check("idle_gain", dut.g_q, 0);

        // Ramp to full gain with full-scale positive input
        for (int i = 0; i < 300; i++) send(16'hFFFF, 8'd255, 1'b0, 16);
        check("full_gain", dut.g_q, 255);
        check("full_level", dut.level_q, 16'hFF7F);
        ones = 0;
        for (int i = 0; i < 65536; i++) begin
            tick();
            if (pdm_out) ones++;
        end
        check("ones_count", ones, 65407);

        // Half gain, most-negative sample -> 25 % density
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gm = 0;
        for (int i = 0; i < 128; i++) send(16'h0000, 8'd128, 1'b0, 10);
        check("half_gain", dut.g_q, 128);
        check("quarter_level", dut.level_q, 16'h4000);
        repeat (4) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            bits[i] = pdm_out;
        end
        check("quarter_ones", $countones(bits), 4);
        for (int i = 0; i < 12; i++) check("quarter_period", bits[i], bits[i+4]);

        // Climb to g=255 on 0xC000, then mute ramps level back to midscale
        for (int i = 0; i < 127; i++) send(16'hC000, 8'd255, 1'b0, 10);
        check("c000_level", dut.level_q, 16'hBFC0);
        prev = dut.level_q;
        for (int i = 0; i < 255; i++) begin
            send(16'hC000, 8'd255, 1'b1, 10);
            diff = int'(prev) - int'(dut.level_q);
            check("mute_step", (diff >= 0 && diff <= 65) ? 1 : 0, 1);
            prev = dut.level_q;
        end
        check("mute_gain", dut.g_q, 0);
        check("mute_level", dut.level_q, 16'h8000);

        // Overrun: second strobe in cycle 5 is dropped
        sample = 16'h4000;
        volume = 8'd200;
        mute = 1'b0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        step_gain(8'd200, 1'b0);
        exp_q.push_back(exp_level(16'h4000, gm));
        check("ovr_before", overrun, 0);
        repeat (4) tick();
        sample = 16'h1234;
        volume = 8'd0;
        mute = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("ovr_set", overrun, 1);
        repeat (3) tick();
        check("ovr_busy9", sample_ready, 0);
        tick();
        check("ovr_ready10", sample_ready, 1);
        check("ovr_gain", dut.g_q, gm);
        check("ovr_level", dut.level_q, exp_q.pop_front());
        send(16'h4000, 8'd200, 1'b0, 16);
        check("ovr_sticky", overrun, 1);

        // Reset in cycle 4 of MULT, with a strobe in the reset cycle
        sample = 16'hFFFF;
        volume = 8'd255;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        sample_valid = 1'b1;
        tick();
        rst = 1'b0;
        sample_valid = 1'b0;
        check("abort_ready", sample_ready, 1);
        check("abort_level", dut.level_q, 16'h8000);
        check("abort_gain", dut.g_q, 0);
        check("abort_overrun", overrun, 0);
        gm = 0;
        tick();
        send(16'hFFFF, 8'd255, 1'b0, 16);
        check("post_abort_level", dut.level_q, 16'h807F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
